// File: rtl/ex_stage.sv
// Execute stage: combinational ALU feeding the EX/MEM pipeline register.
// Handles branch resolution from the held Z/N flags, and squashes the delay slot
// after a taken branch or jump.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] addr,
    input  logic [5:0]  rd,
    input  logic [3:0]  alu_op,
    input  logic        reg_write,
    input  logic        branch_z,
    input  logic        branch_neg,
    input  logic        memtoreg,
    input  logic        pctoreg,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        jump,
    input  logic        jump_mem,
    output logic [31:0] result_out,
    output logic [31:0] rt_out,
    output logic [31:0] addr_out,
    output logic [31:0] target_out,
    output logic [5:0]  rd_out,
    output logic        reg_write_out,
    output logic        memtoreg_out,
    output logic        pctoreg_out,
    output logic        mem_r_out,
    output logic        mem_w_out,
    output logic        jump_mem_out,
    output logic        valid_out,
    output logic        take_branch_out,
    output logic        z_flag,
    output logic        n_flag
);

    logic [31:0] alu_result;
    logic        kill;
    logic        take;
    logic        load_ok;
    logic        flag_upd;

    // ALU: wrap-around 32-bit arithmetic, unused opcodes yield zero
    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = rs;
            4'b0001: alu_result = rs + rt;
            4'b0010: alu_result = rs + addr;
            4'b0011: alu_result = 32'd0 - rs;
            4'b0100: alu_result = rs - rt;
            4'b0101: alu_result = rs & rt;
            4'b0110: alu_result = rs | rt;
            4'b0111: alu_result = rs ^ rt;
            default: alu_result = '0;
        endcase
    end

    // Branch decision and load qualification using flags held before this edge
    always_comb begin
        load_ok  = in_valid & ~kill;
        take     = jump | (branch_z & z_flag) | (branch_neg & n_flag);
        flag_upd = reg_write & ~memtoreg & ~pctoreg & ~alu_op[3];
    end

    // Pipeline register: reset > flush > stall > load (real or bubble)
    always_ff @(posedge clk) begin
        if (reset) begin
            result_out      <= '0;
            rt_out          <= '0;
            addr_out        <= '0;
            target_out      <= '0;
            rd_out          <= '0;
            reg_write_out   <= 1'b0;
            memtoreg_out    <= 1'b0;
            pctoreg_out     <= 1'b0;
            mem_r_out       <= 1'b0;
            mem_w_out       <= 1'b0;
            jump_mem_out    <= 1'b0;
            valid_out       <= 1'b0;
            take_branch_out <= 1'b0;
            z_flag          <= 1'b0;
            n_flag          <= 1'b0;
            kill            <= 1'b0;
        end else if (flush || (!stall && !load_ok)) begin
            // Bubble: flags are preserved, pending squash is consumed
            result_out      <= '0;
            rt_out          <= '0;
            addr_out        <= '0;
            target_out      <= '0;
            rd_out          <= '0;
            reg_write_out   <= 1'b0;
            memtoreg_out    <= 1'b0;
            pctoreg_out     <= 1'b0;
            mem_r_out       <= 1'b0;
            mem_w_out       <= 1'b0;
            jump_mem_out    <= 1'b0;
            valid_out       <= 1'b0;
            take_branch_out <= 1'b0;
            kill            <= 1'b0;
        end else if (!stall) begin
            result_out      <= alu_result;
            rt_out          <= rt;
            addr_out        <= addr;
            target_out      <= rs;
            rd_out          <= rd;
            reg_write_out   <= reg_write;
            memtoreg_out    <= memtoreg;
            pctoreg_out     <= pctoreg;
            mem_r_out       <= mem_r;
            mem_w_out       <= mem_w;
            jump_mem_out    <= jump_mem;
            valid_out       <= 1'b1;
            take_branch_out <= take;
            kill            <= take;
            if (flag_upd) begin
                z_flag <= (alu_result == 32'd0);
                n_flag <= alu_result[31];
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a reference model pushes the expected
// register state per cycle into a scoreboard queue, popped after each edge.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] rs, rt, addr;
    logic [5:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write, branch_z, branch_neg, memtoreg, pctoreg;
    logic        mem_r, mem_w, jump, jump_mem;
    logic [31:0] result_out, rt_out, addr_out, target_out;
    logic [5:0]  rd_out;
    logic        reg_write_out, memtoreg_out, pctoreg_out, mem_r_out, mem_w_out;
    logic        jump_mem_out, valid_out, take_branch_out, z_flag, n_flag;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] rt;
        logic [31:0] addr;
        logic [31:0] target;
        logic [5:0]  rd;
        logic        rw, mtr, ptr, mr, mw, jm, valid, take, z, n;
    } exp_t;

    exp_t q[$];
    exp_t m;
    logic m_kill;
    int   n_checks = 0;
    int   n_errs   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .rs(rs), .rt(rt), .addr(addr), .rd(rd), .alu_op(alu_op),
        .reg_write(reg_write), .branch_z(branch_z), .branch_neg(branch_neg),
        .memtoreg(memtoreg), .pctoreg(pctoreg), .mem_r(mem_r), .mem_w(mem_w),
        .jump(jump), .jump_mem(jump_mem),
        .result_out(result_out), .rt_out(rt_out), .addr_out(addr_out),
        .target_out(target_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .memtoreg_out(memtoreg_out), .pctoreg_out(pctoreg_out), .mem_r_out(mem_r_out),
        .mem_w_out(mem_w_out), .jump_mem_out(jump_mem_out), .valid_out(valid_out),
        .take_branch_out(take_branch_out), .z_flag(z_flag), .n_flag(n_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ad);
        if (op == 4'd0)      return a;
        else if (op == 4'd1) return a + b;
        else if (op == 4'd2) return a + ad;
        else if (op == 4'd3) return -a;
        else if (op == 4'd4) return a - b;
        else if (op == 4'd5) return a & b;
        else if (op == 4'd6) return a | b;
        else if (op == 4'd7) return a ^ b;
        else                 return 32'd0;
    endfunction

    function automatic exp_t bubble_of(input exp_t cur);
        exp_t b;
        b   = '0;
        b.z = cur.z;
        b.n = cur.n;
        return b;
    endfunction

    task automatic compare_all(input exp_t e);
        check("result_out", result_out, e.result);
        check("rt_out", rt_out, e.rt);
        check("addr_out", addr_out, e.addr);
        check("target_out", target_out, e.target);
        check("rd_out", 32'(rd_out), 32'(e.rd));
        check("reg_write_out", 32'(reg_write_out), 32'(e.rw));
        check("memtoreg_out", 32'(memtoreg_out), 32'(e.mtr));
        check("pctoreg_out", 32'(pctoreg_out), 32'(e.ptr));
        check("mem_r_out", 32'(mem_r_out), 32'(e.mr));
        check("mem_w_out", 32'(mem_w_out), 32'(e.mw));
        check("jump_mem_out", 32'(jump_mem_out), 32'(e.jm));
        check("valid_out", 32'(valid_out), 32'(e.valid));
        check("take_branch_out", 32'(take_branch_out), 32'(e.take));
        check("z_flag", 32'(z_flag), 32'(e.z));
        check("n_flag", 32'(n_flag), 32'(e.n));
        if (!valid_out)
            check("no_ctrl_when_invalid", 32'({mem_r_out, mem_w_out, reg_write_out}), 32'd0);
    endtask

    // Apply current inputs to the model, push expectation, clock, pop and compare
    task automatic step();
        exp_t e;
        logic [31:0] res;
        logic take;
        if (reset) begin
            m      = '0;
            m_kill = 1'b0;
        end else if (flush) begin
            m      = bubble_of(m);
            m_kill = 1'b0;
        end else if (!stall) begin
            if (in_valid && !m_kill) begin
                res      = ref_alu(alu_op, rs, rt, addr);
                take     = jump || (branch_z && m.z) || (branch_neg && m.n);
                m.result = res;
                m.rt     = rt;
                m.addr   = addr;
                m.target = rs;
                m.rd     = rd;
                m.rw     = reg_write;
                m.mtr    = memtoreg;
                m.ptr    = pctoreg;
                m.mr     = mem_r;
                m.mw     = mem_w;
                m.jm     = jump_mem;
                m.valid  = 1'b1;
                m.take   = take;
                if (reg_write && !memtoreg && !pctoreg && alu_op < 4'd8) begin
                    m.z = (res == 32'd0);
                    m.n = res[31];
                end
                m_kill = take;
            end else begin
                m      = bubble_of(m);
                m_kill = 1'b0;
            end
        end
        q.push_back(m);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            compare_all(e);
        end
    endtask

    task automatic instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ad);
        in_valid = 1'b1; alu_op = op; rs = a; rt = b; addr = ad; rd = 6'd7;
        reg_write = 0; branch_z = 0; branch_neg = 0; memtoreg = 0; pctoreg = 0;
        mem_r = 0; mem_w = 0; jump = 0; jump_mem = 0;
    endtask

    task automatic rand_inputs();
        in_valid   = $urandom_range(0, 3) != 0;
        alu_op     = 4'($urandom_range(0, 15));
        rs         = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        rt         = ($urandom_range(0, 3) == 0) ? rs : $urandom;
        addr       = $urandom;
        rd         = 6'($urandom);
        reg_write  = $urandom_range(0, 1) == 1;
        branch_z   = $urandom_range(0, 3) == 0;
        branch_neg = $urandom_range(0, 3) == 0;
        memtoreg   = $urandom_range(0, 3) == 0;
        pctoreg    = $urandom_range(0, 5) == 0;
        mem_r      = $urandom_range(0, 3) == 0;
        mem_w      = $urandom_range(0, 3) == 0;
        jump       = $urandom_range(0, 7) == 0;
        jump_mem   = $urandom_range(0, 7) == 0;
    endtask

    initial begin
        m = '0;
        m_kill = 1'b0;
        reset = 1; stall = 0; flush = 0;
        instr(4'd0, 32'd0, 32'd0, 32'd0);
        in_valid = 0;

        // Reset state
        step();
        step();
        check("reset_valid", 32'(valid_out), 32'd0);
        reset = 0;

        // Signed overflow wrap on add
        instr(4'd1, 32'h7FFF_FFFF, 32'd1, 32'd0);
        reg_write = 1;
        step();
        check("add_result", result_out, 32'h8000_0000);
        check("add_nflag", 32'(n_flag), 32'd1);
        check("add_zflag", 32'(z_flag), 32'd0);
        check("add_valid", 32'(valid_out), 32'd1);

        // Every opcode with distinct operands
        for (int unsigned op = 0; op < 16; op++) begin
            instr(4'(op), $urandom, $urandom, $urandom);
            reg_write = 1;
            step();
        end

        // Branch on zero, delay slot squashed
        instr(4'd4, 32'd5, 32'd5, 32'd0);
        reg_write = 1;
        step();
        check("sub_zflag", 32'(z_flag), 32'd1);
        instr(4'd0, 32'h100, 32'd0, 32'd0);
        branch_z = 1;
        step();
        check("bz_take", 32'(take_branch_out), 32'd1);
        check("bz_target", target_out, 32'h100);
        instr(4'd1, 32'd1, 32'd1, 32'd0);
        reg_write = 1;
        step();
        check("slot_valid", 32'(valid_out), 32'd0);
        check("slot_take", 32'(take_branch_out), 32'd0);

        // Stall holds a store through three cycles of changing inputs
        instr(4'd1, 32'h1000, 32'h20, 32'h44);
        mem_w = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1;
            step();
            check("stall_result", result_out, 32'h1020);
            check("stall_memw", 32'(mem_w_out), 32'd1);
            check("stall_take", 32'(take_branch_out), 32'd0);
        end
        stall = 0;

        // Taken jump holds its pulse across a stall, then squashes next
        instr(4'd0, 32'h200, 32'd0, 32'd0);
        jump = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            stall = 1;
            step();
            check("stall_take_hold", 32'(take_branch_out), 32'd1);
        end
        stall = 0;
        instr(4'd1, 32'd3, 32'd4, 32'd0);
        reg_write = 1;
        step();
        check("jump_slot_valid", 32'(valid_out), 32'd0);

        // Flush and stall together: bubble, flags untouched
        instr(4'd1, 32'd5, 32'd0, 32'd0);
        reg_write = 1;
        step();
        instr(4'd1, 32'd0, 32'd0, 32'd0);
        reg_write = 1;
        flush = 1; stall = 1;
        step();
        check("fs_valid", 32'(valid_out), 32'd0);
        check("fs_rw", 32'(reg_write_out), 32'd0);
        check("fs_zflag", 32'(z_flag), 32'd0);
        flush = 0; stall = 0;

        // Flag gating by memtoreg
        instr(4'd3, 32'd1, 32'd0, 32'd0);
        reg_write = 1;
        step();
        check("neg_nflag", 32'(n_flag), 32'd1);
        instr(4'd0, 32'd0, 32'd0, 32'd0);
        reg_write = 1; memtoreg = 1;
        step();
        check("gate_zflag", 32'(z_flag), 32'd0);
        check("gate_nflag", 32'(n_flag), 32'd1);

        // Reset discards pending squash
        instr(4'd0, 32'h300, 32'd0, 32'd0);
        jump = 1;
        step();
        reset = 1;
        step();
        check("rst_take", 32'(take_branch_out), 32'd0);
        check("rst_nflag", 32'(n_flag), 32'd0);
        reset = 0;
        instr(4'd1, 32'd2, 32'd3, 32'd0);
        reg_write = 1;
        step();
        check("post_rst_valid", 32'(valid_out), 32'd1);
        check("post_rst_result", result_out, 32'd5);

        // Random traffic with stalls, flushes and occasional reset
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = $urandom_range(0, 3) == 0;
            flush = $urandom_range(0, 9) == 0;
            reset = $urandom_range(0, 29) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
